// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals around mem_arbiter.
// The arbiter connects through the slave modport; the requesters and memory model use the master modport.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] rdata;
  logic        err;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, mem_ready,
    output cpu_ack, dma_ack, rdata, err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, mem_ready,
    input  cpu_ack, dma_ack, rdata, err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a DMA engine.
// Each access runs IDLE -> ACCESS -> DONE and aborts with err after TIMEOUT wait cycles.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_nxt;
   logic        owner_dma;
   logic        last_gnt_dma;
   logic        we_l;
   logic [15:0] addr_l;
   logic [15:0] wdata_l;
   logic [15:0] rdata_q;
   logic        err_q;
   logic [3:0]  wait_cnt;
   logic        any_req;
   logic        grant_dma;
   logic        timeout_hit;

   // DMA wins only when it is alone or the CPU was the last owner.
   assign any_req     = bus.cpu_req | bus.dma_req;
   assign grant_dma   = bus.dma_req & (~bus.cpu_req | ~last_gnt_dma);
   assign timeout_hit = (wait_cnt == 4'(TIMEOUT - 1));

   // NOTE: the reset is synchronous, so it lives inside the clocked branch
   // and takes effect at the first rising edge that samples it high.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (bus.mem_ready || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all registered state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_dma    <= 1'b0;
         last_gnt_dma <= 1'b1;
         we_l         <= 1'b0;
         addr_l       <= 16'h0000;
         wdata_l      <= 16'h0000;
         rdata_q      <= 16'h0000;
         err_q        <= 1'b0;
         wait_cnt     <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner_dma    <= grant_dma;
                  last_gnt_dma <= grant_dma;
                  we_l         <= grant_dma ? bus.dma_we    : bus.cpu_we;
                  addr_l       <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
                  wdata_l      <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                  wait_cnt     <= 4'd0;
               end
            end
            ACCESS: begin
               if (bus.mem_ready) begin
                  rdata_q <= we_l ? 16'h0000 : bus.mem_rdata;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= 16'h0000;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode only from state and latched registers, never from req inputs.
   assign bus.mem_read  = (state == ACCESS) & ~we_l;
   assign bus.mem_write = (state == ACCESS) &  we_l;
   assign bus.mem_addr  = addr_l;
   assign bus.mem_wdata = wdata_l;
   assign bus.cpu_ack   = (state == DONE) & ~owner_dma;
   assign bus.dma_ack   = (state == DONE) &  owner_dma;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected acks into a queue,
// an independent monitor pops and compares on every ack.
module tb_mem_arbiter;

   localparam logic [15:0] KEY = 16'hACDB;   // memory model returns addr ^ KEY

   typedef struct {
      logic        is_dma;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   ready_delay = 0;   // -1 means memory never answers

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic drive_req(input logic is_dma, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
      if (is_dma) begin
         bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
      end else begin
         bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      end
   endtask

   // Memory model: answers ready_delay cycles into each access.
   initial begin
      int acc_cyc;
      acc_cyc = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write) begin
            bus.mem_ready = (acc_cyc == ready_delay);
            bus.mem_rdata = bus.mem_addr ^ KEY;
            acc_cyc++;
         end else begin
            bus.mem_ready = 1'b0;
            acc_cyc = 0;
         end
      end
   end

   // Monitor: every ack must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
            check("ack_exclusive", {bus.cpu_ack, bus.dma_ack} == 2'b11, 0);
            if (sb.size() == 0) begin
               check("unexpected_ack", 1, 0);
            end else begin
               e = sb.pop_front();
               check("ack_owner", bus.dma_ack, e.is_dma);
               check("ack_rdata", bus.rdata, e.rdata);
               check("ack_err",   bus.err,   e.err);
            end
         end
      end
   end

   task automatic run_access(input string name, input logic is_dma, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input int delay, input bit change_mid, input int exp_strobe);
      exp_t e;
      int   rd_cyc = 0, wr_cyc = 0;
      bit   seen = 0, addr_ok = 1, wdata_ok = 1;
      ready_delay = delay;
      e.is_dma = is_dma;
      e.err    = (delay < 0);
      e.rdata  = (we || delay < 0) ? 16'h0000 : addr ^ KEY;
      sb.push_back(e);
      drive_req(is_dma, 1'b1, we, addr, wdata);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write) begin
            if (bus.mem_read)  rd_cyc++;
            if (bus.mem_write) wr_cyc++;
            if (bus.mem_addr !== addr) addr_ok = 0;
            if (we && bus.mem_wdata !== wdata) wdata_ok = 0;
            if (change_mid && rd_cyc + wr_cyc == 1) drive_req(is_dma, 1'b1, we, ~addr, ~wdata);
         end
         if ((is_dma ? bus.dma_ack : bus.cpu_ack) === 1'b1) begin
            seen = 1;
            drive_req(is_dma, 1'b0, we, addr, wdata);
         end
      end
      check({name, "_ack_seen"},  seen, 1);
      check({name, "_rd_cycles"}, rd_cyc, we ? 0 : exp_strobe);
      check({name, "_wr_cycles"}, wr_cyc, we ? exp_strobe : 0);
      check({name, "_addr_hold"}, addr_ok, 1);
      check({name, "_wdata"},     wdata_ok, 1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_cpu, n_dma;
      bit seen;
      reset = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(negedge clk);
      check("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
      check("rst_acks",    {bus.cpu_ack, bus.dma_ack}, 0);
      check("rst_err",     bus.err, 0);
      check("rst_rdata",   bus.rdata, 16'h0000);
      check("rst_addr",    bus.mem_addr, 16'h0000);
      check("rst_wdata",   bus.mem_wdata, 16'h0000);

      // V2: contention from reset alternates CPU, DMA, CPU, DMA.
      ready_delay = 1;
      sb.push_back('{1'b0, 16'h0011 ^ KEY, 1'b0});
      sb.push_back('{1'b1, 16'h0022 ^ KEY, 1'b0});
      sb.push_back('{1'b0, 16'h0011 ^ KEY, 1'b0});
      sb.push_back('{1'b1, 16'h0022 ^ KEY, 1'b0});
      drive_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
      drive_req(1'b1, 1'b1, 1'b0, 16'h0022, 16'h0000);
      reset = 1'b0;
      n_cpu = 0;
      n_dma = 0;
      for (int i = 0; i < 100 && (n_cpu + n_dma) < 4; i++) begin
         @(negedge clk);
         if (!bus.cpu_req && n_cpu < 2) bus.cpu_req = 1'b1;
         if (!bus.dma_req && n_dma < 2) bus.dma_req = 1'b1;
         if (bus.cpu_ack === 1'b1) begin n_cpu++; bus.cpu_req = 1'b0; end
         if (bus.dma_ack === 1'b1) begin n_dma++; bus.dma_req = 1'b0; end
      end
      check("rr_cpu_grants", n_cpu, 2);
      check("rr_dma_grants", n_dma, 2);
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      @(negedge clk);

      // V1, V3, V5, V4.
      run_access("v1_read",    1'b0, 1'b0, 16'h1234, 16'h0000, 2,  1'b0, 3);
      run_access("v3_write",   1'b1, 1'b1, 16'h8000, 16'h00FF, 0,  1'b0, 1);
      run_access("v5_addrchg", 1'b0, 1'b0, 16'h4321, 16'h0000, 3,  1'b1, 4);
      run_access("v4_timeout", 1'b1, 1'b0, 16'h0F0F, 16'h0000, -1, 1'b0, 15);

      // V6: reset mid-ACCESS abandons the CPU access and re-arms CPU priority.
      ready_delay = -1;
      drive_req(1'b0, 1'b1, 1'b0, 16'h5555, 16'h0000);
      repeat (2) @(negedge clk);
      check("v6_in_access", bus.mem_read, 1);
      reset = 1'b1;
      @(negedge clk);
      check("v6_strobes_low", {bus.mem_read, bus.mem_write}, 0);
      check("v6_no_ack",      {bus.cpu_ack, bus.dma_ack}, 0);
      reset = 1'b0;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      ready_delay = 0;
      sb.push_back('{1'b0, 16'hACE8, 1'b0});
      drive_req(1'b0, 1'b1, 1'b0, 16'h0033, 16'h0000);
      drive_req(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
            seen = 1;
            bus.cpu_req = 1'b0;
            bus.dma_req = 1'b0;
         end
      end
      check("v6_regrant_seen", seen, 1);
      repeat (3) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, wait-cycle limit before abort (legal 1..15).
REQ-002 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata until cpu_ack.
REQ-005 SHALL have cpu_we  in  1  1=write, 0=read.
REQ-006 SHALL have cpu_addr  in  16  word address.
REQ-007 SHALL have cpu_wdata  in  16  write data.
REQ-008 SHALL have cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-009 SHALL have dma_req  in  1  DMA access request; same holding rule as cpu_req.
REQ-010 SHALL have dma_we  in  1  1=write, 0=read.
REQ-011 SHALL have dma_addr  in  16  word address.
REQ-012 SHALL have dma_wdata  in  16  write data.
REQ-013 SHALL have dma_ack  out  1  one-cycle completion pulse to DMA.
REQ-014 SHALL have rdata  out  16  read data; valid only in the cycle either ack is high.
REQ-015 SHALL have err  out  1  timeout flag; valid only with an ack.
REQ-016 SHALL have mem_read  out  1  memory read strobe.
REQ-017 SHALL have mem_write  out  1  memory write strobe.
REQ-018 SHALL have mem_addr  out  16  memory address.
REQ-019 SHALL have mem_wdata  out  16  memory write data.
REQ-020 SHALL have mem_rdata  in  16  memory read data, sampled when mem_ready high.
REQ-021 SHALL have mem_ready  in  1  memory completion, sampled only in ACCESS.

Function
REQ-022 SHALL implement states IDLE, ACCESS, DONE; one access in flight at a time.
REQ-023 IDLE: if any req high, SHALL select owner, latch owner's we/addr/wdata into internal registers, clear wait counter, go ACCESS; else stay IDLE.
REQ-024 Arbitration SHALL be round-robin: only one req -> that requester; both -> requester not granted last; last_gnt reg updates at grant.
REQ-025 ACCESS: mem_read = ~we_latched, mem_write = we_latched, mem_addr/mem_wdata from latched registers, stable for whole state.
REQ-026 ACCESS with mem_ready=1: SHALL capture mem_rdata (reads) into rdata register, err<=0, go DONE.
REQ-027 ACCESS with mem_ready=0: wait counter SHALL increment; at count == TIMEOUT SHALL go DONE with err<=1, rdata<=16'h0000, strobes dropped.
REQ-028 DONE: owner's ack SHALL be 1 for exactly this cycle, other ack 0; strobes 0; next state IDLE unconditionally.
REQ-029 Requester SHALL drop or change req at DONE edge; a req still high in the following IDLE is a new access (minimum 3 cycles per access).
REQ-030 On writes rdata SHALL hold 16'h0000 during ack.
REQ-031 Request changes during ACCESS/DONE SHALL have no effect on the in-flight access (latched values used).
REQ-032 mem_ready high outside ACCESS SHALL be ignored.
REQ-033 All outputs SHALL be registered or decoded from state/latched registers only; no combinational path from req inputs to mem_*.

Reset
REQ-034 On reset: state IDLE, all strobes/acks/err 0, rdata/mem_addr/mem_wdata 16'h0000, wait counter 0, last_gnt = DMA (so CPU wins first contention).
REQ-035 Reset mid-ACCESS or mid-DONE SHALL abandon the access: no ack issued, strobes low the cycle after reset sampled.

Verification
V1: cpu_req read addr 16'h1234, mem_ready 2 cycles later with 16'hBEEF -> mem_read high 3 cycles, cpu_ack pulse, rdata=16'hBEEF, err=0.
V2: cpu_req and dma_req both high from reset -> CPU granted first, then DMA; alternates across 4 back-to-back accesses.
V3: dma write 16'h00FF to 16'h8000, mem_ready immediately -> mem_write 1 cycle, mem_wdata=16'h00FF, dma_ack pulse, rdata=0.
V4: mem_ready never asserted, TIMEOUT=15 -> 15 cycles in ACCESS, then ack with err=1, rdata=0.
V5: cpu_addr changed mid-ACCESS -> mem_addr remains original value until DONE.
V6: reset asserted during ACCESS -> no ack, strobes 0 next cycle, next contention grants CPU.
